// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, requests imem words, feeds decode with instr/pc_if2id.
// Latency: one cycle from imem_valid to instr; at most one request outstanding.
// Backpressure: ide_wait freezes decode outputs; a one-entry skid buffer parks a word returned during a stall.
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        ide_wait,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_if2id
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] skid_dat;
    logic [31:0] skid_pc;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~32'h3;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (redirect)
                    state_nxt = imem_valid ? FETCH : DROP;
                else if (imem_valid && ide_wait)
                    state_nxt = HOLD;
            end
            HOLD:  if (redirect || !ide_wait) state_nxt = FETCH;
            // a redirect while draining only retargets pc; the old response still has to land
            DROP:  if (imem_valid) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state == FETCH) || (state == DROP);
        imem_addr = (state == DROP) ? drop_addr : pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            drop_addr <= RESET_PC;
            instr     <= NOP_INSTR;
            pc_if2id  <= 32'h0;
            skid_dat  <= 32'h0;
            skid_pc   <= 32'h0;
        end else if (redirect) begin
            pc    <= redirect_tgt;
            instr <= NOP_INSTR;
            if (state == FETCH)
                drop_addr <= pc;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        pc <= pc + 32'd4;
                        if (ide_wait) begin
                            skid_dat <= imem_rdata;
                            skid_pc  <= pc;
                        end else begin
                            instr    <= imem_rdata;
                            pc_if2id <= pc;
                        end
                    end else if (!ide_wait) begin
                        instr <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (!ide_wait) begin
                        instr    <= skid_dat;
                        pc_if2id <= skid_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed + randomized bench for ifetch against a transaction-level model of the fetch/decode contract.
module tb_ifetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        ide_wait;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] pc_if2id;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        imem_valid2;
    logic        ide_wait2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'h0;
    logic [31:0] instr2;
    logic [31:0] pc_if2id2;

    always #5 clk = ~clk;

    ifetch dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid), .ide_wait(ide_wait),
        .redirect(redirect), .redirect_pc(redirect_pc), .instr(instr), .pc_if2id(pc_if2id)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_valid(imem_valid2), .ide_wait(ide_wait2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .instr(instr2), .pc_if2id(pc_if2id2)
    );

    // zero-wait memory for the wrap-around instance
    assign imem_valid2 = imem_req2;
    assign imem_rdata2 = imem_addr2 ^ KEY;

    int tests = 0;
    int fails = 0;

    // memory model for the main instance: each request answers after `lat` held cycles
    int lat = 1;
    int age = 0;
    bit lat_rand = 1'b0;

    // reference model: what decode sees and what memory is being asked for
    logic [31:0] m_pc, m_instr, m_pcid, m_drop_addr;
    bit          m_idle, m_dropping;
    logic [63:0] m_skid[$];

    function automatic logic m_req();
        return !m_idle && (m_skid.size() == 0);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_dropping ? m_drop_addr : m_pc;
    endfunction

    task automatic m_step(input logic r, input logic v, input logic [31:0] d,
                          input logic w, input logic rd, input logic [31:0] rp);
        if (r) begin
            m_pc = 32'h0; m_instr = NOP; m_pcid = 32'h0; m_drop_addr = 32'h0;
            m_idle = 1'b1; m_dropping = 1'b0; m_skid.delete();
        end else if (rd) begin
            if (m_dropping) begin
                if (v) m_dropping = 1'b0;
            end else if (!m_idle && m_skid.size() == 0 && !v) begin
                m_dropping  = 1'b1;
                m_drop_addr = m_pc;
            end
            m_pc    = {rp[31:2], 2'b00};
            m_instr = NOP;
            m_idle  = 1'b0;
            m_skid.delete();
        end else if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_dropping) begin
            if (v) m_dropping = 1'b0;
        end else if (m_skid.size() != 0) begin
            if (!w) {m_instr, m_pcid} = m_skid.pop_front();
        end else if (v) begin
            if (w) m_skid.push_back({d, m_pc});
            else begin
                m_instr = d;
                m_pcid  = m_pc;
            end
            m_pc = m_pc + 32'd4;
        end else if (!w) begin
            m_instr = NOP;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [31:0] rp, input logic junk);
        logic        pre_req;
        logic        pre_v;
        logic [31:0] pre_d;
        rst = r; ide_wait = w; redirect = rd; redirect_pc = rp;
        imem_valid = junk || (imem_req === 1'b1 && age >= lat);
        imem_rdata = (imem_valid && imem_req === 1'b1) ? (imem_addr ^ KEY) : $urandom();
        pre_req = imem_req; pre_v = imem_valid; pre_d = imem_rdata;
        @(posedge clk);
        m_step(r, pre_v, pre_d, w, rd, rp);
        if (r) age = 0;
        else if (pre_req === 1'b1 && pre_v) begin
            age = 0;
            if (lat_rand) lat = $urandom_range(0, 3);
        end else if (pre_req === 1'b1) age++;
        else age = 0;
        #1;
        chk("model_req",   {31'h0, imem_req}, {31'h0, m_req()});
        chk("model_addr",  imem_addr, m_addr());
        chk("model_instr", instr,     m_instr);
        chk("model_pcid",  pc_if2id,  m_pcid);
    endtask

    initial begin
        rst = 1'b1; ide_wait = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_valid = 1'b0; imem_rdata = 32'h0;

        // reset, with a stale valid in the second reset cycle
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_pcid",  pc_if2id, 32'h0);
        chk("wrap_rst_addr", imem_addr2, 32'hFFFF_FFF8);

        // sequential fetch, memory one cycle behind req
        cyc(0, 0, 0, 0, 0);
        chk("seq_req0", {31'h0, imem_req}, 32'h1);
        chk("wrap_addr0", imem_addr2, 32'hFFFF_FFF8);
        cyc(0, 0, 0, 0, 0);
        chk("seq_bubble", instr, NOP);
        chk("wrap_addr1", imem_addr2, 32'hFFFF_FFFC);
        chk("wrap_instr1", instr2, 32'h5A5A_FFF8);
        cyc(0, 0, 0, 0, 0);
        chk("seq_instr0", instr, 32'hA5A5_0000);
        chk("wrap_addr2", imem_addr2, 32'h0000_0000);
        chk("wrap_pcid2", pc_if2id2, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("seq_instr1", instr, 32'hA5A5_0004);
        chk("seq_pcid1", pc_if2id, 32'h4);
        chk("seq_addr2", imem_addr, 32'h8);

        // stall across the response for address 8
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("hold_req", {31'h0, imem_req}, 32'h0);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("hold_instr", instr, 32'hA5A5_0004);
        chk("hold_pcid", pc_if2id, 32'h4);
        cyc(0, 0, 0, 0, 0);
        chk("release_instr", instr, 32'hA5A5_0008);
        chk("release_pcid", pc_if2id, 32'h8);
        chk("release_addr", imem_addr, 32'hC);

        // redirect while the request to 0x10 is still pending
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        lat = 3;
        cyc(0, 0, 1, 32'h0000_0103, 0);
        chk("drop_addr0", imem_addr, 32'h10);
        chk("drop_instr", instr, NOP);
        chk("drop_pcid", pc_if2id, 32'hC);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("drop_addr2", imem_addr, 32'h10);
        cyc(0, 0, 0, 0, 0);
        chk("drop_done_addr", imem_addr, 32'h100);
        chk("drop_done_instr", instr, NOP);
        lat = 1;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("tgt_instr", instr, 32'hA5A5_0100);
        chk("tgt_pcid", pc_if2id, 32'h100);

        // redirect together with a response and a stall
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h0000_0200, 0);
        chk("rdv_instr", instr, NOP);
        chk("rdv_addr", imem_addr, 32'h200);
        chk("rdv_pcid", pc_if2id, 32'h100);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("rdv_next", instr, 32'hA5A5_0200);

        // reset from DROP
        lat = 3;
        cyc(0, 0, 1, 32'h0000_0300, 0);
        cyc(1, 0, 0, 0, 1);
        chk("rst_drop_req", {31'h0, imem_req}, 32'h0);
        chk("rst_drop_instr", instr, NOP);
        chk("rst_drop_pcid", pc_if2id, 32'h0);
        lat = 1;
        cyc(0, 0, 0, 0, 0);
        chk("rst_drop_first", imem_addr, 32'h0);

        // reset from HOLD
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 1);
        chk("rst_hold_addr", imem_addr, 32'h0);
        chk("rst_hold_instr", instr, NOP);
        cyc(0, 0, 0, 0, 0);
        chk("rst_hold_first", imem_addr, 32'h0);

        // randomized traffic with random memory latency
        lat_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 99) < 8), $urandom(), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
